// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared definitions for the instruction/data bus arbiter: FSM state encoding,
// default bus widths and the pipeline's enable/stall polarity constants.
package ibus_dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INST      = 2'd1,
        ST_DATA      = 2'd2,
        ST_INST_DROP = 2'd3
    } arb_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    function automatic int sel_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ibus_dbus_arbiter_bus_wait_timer.sv
// Wait-cycle counter for an outstanding bus request; expire fires when the
// count reaches LIMIT while still waiting. LIMIT = 0 disables expiry.
module ibus_dbus_arbiter_bus_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT so a held request never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT_C)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (LIMIT > 0) && en && (cnt == LIMIT_C);

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access. Data wins
// in IDLE; flushed fetches finish on the bus but their result is discarded.
module ibus_dbus_arbiter
    import ibus_dbus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = sel_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_done_o,
    output logic              stallreq_if_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [SEL_W-1:0]  data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_done_o,
    output logic              stallreq_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              timeout_o
);

    arb_state_t        state, state_nxt;
    logic              inst_pend, data_pend, ack_v, waiting, expire;
    logic              timer_clr, timer_en;
    logic              start_data, start_inst, bus_end, data_fin, inst_fin;
    logic [DATA_W-1:0] rdata_v;

    // A request still high in its own done cycle is the one just served, so
    // the stall terms double as "pending" qualifiers for starting an access.
    assign stallreq_if_o  = (inst_req_i & ~inst_done_o) ? STOP : NO_STOP;
    assign stallreq_mem_o = (data_req_i & ~data_done_o) ? STOP : NO_STOP;
    assign inst_pend      = stallreq_if_o;
    assign data_pend      = stallreq_mem_o;

    assign ack_v     = bus_req_o & bus_ack_i;
    assign waiting   = (state != ST_IDLE);
    assign timer_clr = (state == ST_IDLE) | ((state == ST_INST) & flush & ~ack_v);
    assign timer_en  = waiting & ~ack_v;
    assign rdata_v   = ack_v ? bus_rdata_i : '0;

    ibus_dbus_arbiter_bus_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (data_pend)                  state_nxt = ST_DATA;
                else if (inst_pend && !flush)   state_nxt = ST_INST;
            end
            ST_DATA: begin
                if (ack_v || expire)            state_nxt = ST_IDLE;
            end
            ST_INST: begin
                if (ack_v || expire)            state_nxt = ST_IDLE;
                else if (flush)                 state_nxt = ST_INST_DROP;
            end
            ST_INST_DROP: begin
                if (ack_v || expire)            state_nxt = ST_IDLE;
            end
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_data = 1'b0;
        start_inst = 1'b0;
        data_fin   = 1'b0;
        inst_fin   = 1'b0;
        bus_end    = waiting & (ack_v | expire);
        case (state)
            ST_IDLE: begin
                start_data = data_pend;
                start_inst = ~data_pend & inst_pend & ~flush;
            end
            ST_DATA: data_fin = bus_end;
            ST_INST: inst_fin = bus_end & ~flush;
            default: ;
        endcase
    end

    // Bus fields are loaded only when a request starts, so they stay stable while bus_req_o is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_o    <= CHIP_DISABLE;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= '0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
            inst_done_o  <= 1'b0;
            data_done_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            inst_done_o <= inst_fin;
            data_done_o <= data_fin;
            timeout_o   <= expire;
            if (start_data) begin
                bus_req_o   <= CHIP_ENABLE;
                bus_we_o    <= data_we_i;
                bus_sel_o   <= data_sel_i;
                bus_addr_o  <= data_addr_i;
                bus_wdata_o <= data_wdata_i;
            end else if (start_inst) begin
                bus_req_o   <= CHIP_ENABLE;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= '1;
                bus_addr_o  <= inst_addr_i;
                bus_wdata_o <= '0;
            end else if (bus_end) begin
                bus_req_o   <= CHIP_DISABLE;
            end
            if (data_fin) data_rdata_o <= rdata_v;
            if (inst_fin) inst_rdata_o <= rdata_v;
        end
    end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Scoreboard bench for ibus_dbus_arbiter: stimulus queues expected bus requests
// and completions; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_ibus_dbus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_rdata_o;
    logic        inst_done_o;
    logic        stallreq_if_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_sel_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_done_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
    } done_exp_t;

    bus_exp_t    exp_bus[$];
    logic [31:0] exp_inst[$];
    done_exp_t   exp_data[$];

    ibus_dbus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .inst_req_i     (inst_req_i),
        .inst_addr_i    (inst_addr_i),
        .inst_rdata_o   (inst_rdata_o),
        .inst_done_o    (inst_done_o),
        .stallreq_if_o  (stallreq_if_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_sel_i     (data_sel_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_done_o    (data_done_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_bus_req(input string name);
        int t = 0;
        while (bus_req_o !== 1'b1 && t < 20) begin
            cyc(1);
            t++;
        end
        chk(name, {31'b0, bus_req_o}, 32'd1);
    endtask

    task automatic ack_now(input logic [31:0] rd);
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd;
        cyc(1);
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    // Monitor: bus request fields on each rising bus_req_o, completions on each done pulse.
    initial begin
        logic     prev_req;
        bus_exp_t cur;
        done_exp_t de;
        prev_req = 1'b0;
        cur = '{1'b0, 4'h0, 32'h0, 32'h0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus_req_o && !prev_req) begin
                    chk("bus_req_expected", {31'b0, exp_bus.size() != 0}, 32'd1);
                    if (exp_bus.size() != 0) begin
                        cur = exp_bus.pop_front();
                        chk("bus_we", {31'b0, bus_we_o}, {31'b0, cur.we});
                        chk("bus_sel", {28'b0, bus_sel_o}, {28'b0, cur.sel});
                        chk("bus_addr", bus_addr_o, cur.addr);
                        chk("bus_wdata", bus_wdata_o, cur.wdata);
                    end
                end else if (bus_req_o) begin
                    chk("bus_addr_stable", bus_addr_o, cur.addr);
                end
                if (inst_done_o) begin
                    chk("inst_done_expected", {31'b0, exp_inst.size() != 0}, 32'd1);
                    if (exp_inst.size() != 0) chk("inst_rdata", inst_rdata_o, exp_inst.pop_front());
                    chk("inst_timeout_flag", {31'b0, timeout_o}, 32'd0);
                end
                if (data_done_o) begin
                    chk("data_done_expected", {31'b0, exp_data.size() != 0}, 32'd1);
                    if (exp_data.size() != 0) begin
                        de = exp_data.pop_front();
                        chk("data_rdata", data_rdata_o, de.rdata);
                        chk("data_timeout_flag", {31'b0, timeout_o}, {31'b0, de.to});
                    end
                end
                if (timeout_o) chk("timeout_with_done", {31'b0, data_done_o}, 32'd1);
                prev_req = bus_req_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;

        // Reset state
        rst = 1'b1;
        cyc(3);
        chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
        chk("rst_inst_done", {31'b0, inst_done_o}, 32'd0);
        chk("rst_data_done", {31'b0, data_done_o}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_inst_rdata", inst_rdata_o, 32'd0);
        chk("rst_data_rdata", data_rdata_o, 32'd0);
        rst = 1'b0;
        cyc(1);

        // 1: fetch only, ack two cycles after bus_req
        inst_addr_i = 32'hBFC0_0000;
        inst_req_i  = 1'b1;
        exp_bus.push_back('{1'b0, 4'hF, 32'hBFC0_0000, 32'h0});
        exp_inst.push_back(32'h1234_5678);
        #1;
        chk("t1_stall_if_pending", {31'b0, stallreq_if_o}, 32'd1);
        wait_bus_req("t1_bus_req");
        cyc(2);
        chk("t1_stall_before_done", {31'b0, stallreq_if_o}, 32'd1);
        ack_now(32'h1234_5678);
        chk("t1_done_pulse", {31'b0, inst_done_o}, 32'd1);
        chk("t1_stall_in_done", {31'b0, stallreq_if_o}, 32'd0);
        inst_req_i = 1'b0;
        cyc(1);
        chk("t1_done_low", {31'b0, inst_done_o}, 32'd0);
        chk("t1_rdata_held", inst_rdata_o, 32'h1234_5678);

        // 2: contention, data write wins, fetch follows the data done cycle
        inst_addr_i  = 32'h8000_0100;
        inst_req_i   = 1'b1;
        data_addr_i  = 32'h8000_1000;
        data_we_i    = 1'b1;
        data_sel_i   = 4'b0011;
        data_wdata_i = 32'hCAFE_F00D;
        data_req_i   = 1'b1;
        exp_bus.push_back('{1'b1, 4'b0011, 32'h8000_1000, 32'hCAFE_F00D});
        exp_bus.push_back('{1'b0, 4'hF, 32'h8000_0100, 32'h0});
        exp_data.push_back('{32'h1111_2222, 1'b0});
        exp_inst.push_back(32'h3333_4444);
        wait_bus_req("t2_data_bus_req");
        chk("t2_bus_we", {31'b0, bus_we_o}, 32'd1);
        cyc(1);
        ack_now(32'h1111_2222);
        chk("t2_data_done", {31'b0, data_done_o}, 32'd1);
        chk("t2_bus_idle_in_done", {31'b0, bus_req_o}, 32'd0);
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        cyc(1);
        chk("t2_fetch_start", {31'b0, bus_req_o}, 32'd1);
        chk("t2_fetch_addr", bus_addr_o, 32'h8000_0100);
        ack_now(32'h3333_4444);
        chk("t2_inst_done", {31'b0, inst_done_o}, 32'd1);
        inst_req_i = 1'b0;
        cyc(2);

        // 3: flush one cycle into a fetch, ack three cycles after the flush
        inst_addr_i = 32'h0040_0000;
        inst_req_i  = 1'b1;
        exp_bus.push_back('{1'b0, 4'hF, 32'h0040_0000, 32'h0});
        wait_bus_req("t3_bus_req");
        cyc(1);
        flush       = 1'b1;
        inst_addr_i = 32'h0040_0100;
        cyc(1);
        flush = 1'b0;
        chk("t3_req_held_after_flush", {31'b0, bus_req_o}, 32'd1);
        chk("t3_addr_stable", bus_addr_o, 32'h0040_0000);
        cyc(1);
        chk("t3_req_still_held", {31'b0, bus_req_o}, 32'd1);
        cyc(1);
        exp_bus.push_back('{1'b0, 4'hF, 32'h0040_0100, 32'h0});
        exp_inst.push_back(32'h5555_6666);
        ack_now(32'hAAAA_0000);
        chk("t3_no_done", {31'b0, inst_done_o}, 32'd0);
        chk("t3_bus_req_low", {31'b0, bus_req_o}, 32'd0);
        chk("t3_stall_if_still", {31'b0, stallreq_if_o}, 32'd1);
        cyc(1);
        chk("t3_refetch_start", {31'b0, bus_req_o}, 32'd1);
        ack_now(32'h5555_6666);
        chk("t3_refetch_done", {31'b0, inst_done_o}, 32'd1);
        inst_req_i = 1'b0;
        cyc(2);

        // 4: flush during a data read is ignored
        data_addr_i  = 32'h8000_2000;
        data_we_i    = 1'b0;
        data_sel_i   = 4'hF;
        data_wdata_i = 32'h0;
        data_req_i   = 1'b1;
        exp_bus.push_back('{1'b0, 4'hF, 32'h8000_2000, 32'h0});
        exp_data.push_back('{32'hDEAD_BEEF, 1'b0});
        wait_bus_req("t4_bus_req");
        cyc(1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("t4_req_held", {31'b0, bus_req_o}, 32'd1);
        ack_now(32'hDEAD_BEEF);
        chk("t4_data_done", {31'b0, data_done_o}, 32'd1);
        data_req_i = 1'b0;
        cyc(1);
        chk("t4_rdata_held", data_rdata_o, 32'hDEAD_BEEF);

        // 5: data read with no ack; counter 0..TO then abort, so bus_req is high TO+1 cycles
        data_addr_i = 32'h8000_3000;
        data_req_i  = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        exp_bus.push_back('{1'b0, 4'hF, 32'h8000_3000, 32'h0});
        exp_data.push_back('{32'h0, 1'b1});
        wait_bus_req("t5_bus_req");
        hi = 0;
        while (bus_req_o === 1'b1 && hi < 20) begin
            hi++;
            cyc(1);
        end
        chk("t5_req_high_cycles", hi, TO + 1);
        chk("t5_timeout", {31'b0, timeout_o}, 32'd1);
        chk("t5_data_done", {31'b0, data_done_o}, 32'd1);
        chk("t5_data_rdata_zero", data_rdata_o, 32'd0);
        data_req_i  = 1'b0;
        bus_rdata_i = '0;
        cyc(1);
        chk("t5_timeout_pulse_end", {31'b0, timeout_o}, 32'd0);

        // 6: reset in the middle of a fetch, then a late ack
        inst_addr_i = 32'h0050_0000;
        inst_req_i  = 1'b1;
        exp_bus.push_back('{1'b0, 4'hF, 32'h0050_0000, 32'h0});
        wait_bus_req("t6_bus_req");
        cyc(1);
        rst        = 1'b1;
        inst_req_i = 1'b0;
        cyc(1);
        chk("t6_bus_req_zero", {31'b0, bus_req_o}, 32'd0);
        chk("t6_bus_addr_zero", bus_addr_o, 32'd0);
        chk("t6_inst_rdata_zero", inst_rdata_o, 32'd0);
        chk("t6_stall_if_zero", {31'b0, stallreq_if_o}, 32'd0);
        chk("t6_stall_mem_zero", {31'b0, stallreq_mem_o}, 32'd0);
        rst = 1'b0;
        ack_now(32'h7777_8888);
        chk("t6_late_ack_no_done", {31'b0, inst_done_o}, 32'd0);
        chk("t6_late_ack_rdata", inst_rdata_o, 32'd0);
        chk("t6_late_ack_bus_req", {31'b0, bus_req_o}, 32'd0);
        cyc(2);

        chk("queues_empty", exp_bus.size() + exp_inst.size() + exp_data.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
